// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter.
// Holds the FSM state encoding, bus widths and the timeout read-data default.
package wb_rr_arbiter_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int IDX_W       = 3;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;

    localparam logic [DATA_W-1:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE,
        OWNED
    } arb_state_t;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] onehot);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (onehot[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_pick.sv
// Purely combinational round-robin picker: the winner is the first requester
// strictly after last_owner, wrapping around the request vector.
module rr_pick
    import wb_rr_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [N-1:0]     winner,
    output logic             valid
);

    // Outer loop walks priority order (offset from last_owner), inner loop
    // matches that position so every index is a plain loop variable.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!valid && req[i] && (i == (int'(last_owner) + 1 + k) % N)) begin
                    winner[i] = 1'b1;
                    valid     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one downstream Wishbone bus among N_MASTERS
// requesters, with locked ownership and a forced-termination timeout.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int                 N_MASTERS      = 2,
    parameter int                 TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0]  TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT
) (
    input  logic                          wb_clk,
    input  logic                          wb_rst_n,

    input  logic [N_MASTERS-1:0]          s_cyc,
    input  logic [N_MASTERS-1:0]          s_stb,
    input  logic [N_MASTERS-1:0]          s_we,
    input  logic [N_MASTERS*ADDR_W-1:0]   s_adr,
    input  logic [N_MASTERS*DATA_W-1:0]   s_wdata,
    output logic [N_MASTERS*DATA_W-1:0]   s_rdata,
    output logic [N_MASTERS-1:0]          s_ack,

    output logic                          m_cyc,
    output logic                          m_stb,
    output logic                          m_we,
    output logic [ADDR_W-1:0]             m_adr,
    output logic [DATA_W-1:0]             m_wdata,
    input  logic [DATA_W-1:0]             m_rdata,
    input  logic                          m_ack,

    output logic [N_MASTERS-1:0]          grant,
    output logic [15:0]                   timeout_count
);

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    arb_state_t          state;
    logic [IDX_W-1:0]    owner_idx;
    logic [IDX_W-1:0]    last_owner;
    logic [15:0]         wait_cnt;
    logic                fire;

    logic [N_MASTERS-1:0] pick_winner;
    logic                 pick_valid;

    logic                owner_cyc;
    logic                owner_stb;
    logic                owner_we;
    logic [ADDR_W-1:0]   owner_adr;
    logic [DATA_W-1:0]   owner_wdata;
    logic                live;

    rr_pick #(.N(N_MASTERS)) u_pick (
        .req        (s_cyc),
        .last_owner (last_owner),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    // grant is only non-zero while OWNED, so it doubles as the owner select.
    always_comb begin
        owner_cyc   = 1'b0;
        owner_stb   = 1'b0;
        owner_we    = 1'b0;
        owner_adr   = '0;
        owner_wdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant[i]) begin
                owner_cyc   = s_cyc[i];
                owner_stb   = s_stb[i];
                owner_we    = s_we[i];
                owner_adr   = s_adr[i*ADDR_W +: ADDR_W];
                owner_wdata = s_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Reset gates the bus combinationally so an in-flight transfer drops at once;
    // fire is registered, keeping m_stb free of any path from m_ack.
    always_comb begin
        live    = (state == OWNED) && wb_rst_n;
        m_cyc   = live && owner_cyc && !fire;
        m_stb   = live && owner_stb && !fire;
        m_we    = live && owner_we;
        m_adr   = live ? owner_adr   : '0;
        m_wdata = live ? owner_wdata : '0;
        s_ack   = '0;
        s_rdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (live && grant[i]) begin
                s_ack[i]                     = fire || m_ack;
                s_rdata[i*DATA_W +: DATA_W]  = fire ? TIMEOUT_DATA : m_rdata;
            end
        end
    end

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values, independent of statement order.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state         <= IDLE;
            grant         <= '0;
            owner_idx     <= '0;
            last_owner    <= IDX_W'(N_MASTERS - 1);
            wait_cnt      <= '0;
            fire          <= 1'b0;
            timeout_count <= '0;
        end else begin
            if (state == OWNED && fire && timeout_count != 16'hFFFF) begin
                timeout_count <= timeout_count + 16'd1;
            end
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    fire     <= 1'b0;
                    if (pick_valid) begin
                        state     <= OWNED;
                        grant     <= pick_winner;
                        owner_idx <= onehot_to_idx(MAX_MASTERS'(pick_winner));
                    end
                end
                OWNED: begin
                    if (!owner_cyc) begin
                        state      <= IDLE;
                        grant      <= '0;
                        last_owner <= owner_idx;
                        wait_cnt   <= '0;
                        fire       <= 1'b0;
                    end else if (fire) begin
                        fire     <= 1'b0;
                        wait_cnt <= '0;
                    end else if (m_ack || !owner_stb) begin
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        fire <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed table, corner-case
// sequences, then randomized traffic against a behavioural model.
module tb_wb_rr_arbiter;

    localparam int          N  = 3;
    localparam int          T  = 16;
    localparam logic [31:0] TD = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      s_cyc, s_stb, s_we, s_ack;
    logic [N*32-1:0]   s_adr, s_wdata, s_rdata;
    logic              m_cyc, m_stb, m_we, m_ack;
    logic [31:0]       m_adr, m_wdata, m_rdata;
    logic [N-1:0]      grant;
    logic [15:0]       timeout_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter #(.N_MASTERS(N), .TIMEOUT_CYCLES(T), .TIMEOUT_DATA(TD)) dut (
        .wb_clk        (clk),
        .wb_rst_n      (rst_n),
        .s_cyc         (s_cyc),
        .s_stb         (s_stb),
        .s_we          (s_we),
        .s_adr         (s_adr),
        .s_wdata       (s_wdata),
        .s_rdata       (s_rdata),
        .s_ack         (s_ack),
        .m_cyc         (m_cyc),
        .m_stb         (m_stb),
        .m_we          (m_we),
        .m_adr         (m_adr),
        .m_wdata       (m_wdata),
        .m_rdata       (m_rdata),
        .m_ack         (m_ack),
        .grant         (grant),
        .timeout_count (timeout_count)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s_cyc   = '0;
        s_stb   = '0;
        s_we    = '0;
        s_adr   = '0;
        s_wdata = '0;
        m_ack   = 1'b0;
        m_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_master(input int i, input logic c, input logic s);
        s_cyc[i] = c;
        s_stb[i] = s;
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic         rst_n;
        logic [N-1:0] cyc;
        logic         ack;
        logic [N-1:0] eg;
        logic         emcyc;
        logic [N-1:0] esack;
    } vec_t;

    vec_t tbl [31];

    // ---------------- behavioural model ----------------
    bit md_owned;
    int md_owner, md_last, md_stall, md_tcount;

    task automatic model_reset();
        md_owned  = 0;
        md_owner  = 0;
        md_last   = N - 1;
        md_stall  = 0;
        md_tcount = 0;
    endtask

    task automatic model_check();
        bit            live, forced;
        logic [66:0]   e_mbus;
        logic [N-1:0]  e_sack, e_grant;
        logic [N*32-1:0] e_srd;
        live   = rst_n && md_owned;
        forced = md_owned && (md_stall == T);
        e_mbus = '0;
        e_sack = '0;
        e_srd  = '0;
        if (live) begin
            e_mbus = {s_cyc[md_owner] && !forced, s_stb[md_owner] && !forced, s_we[md_owner],
                      s_adr[md_owner*32 +: 32], s_wdata[md_owner*32 +: 32]};
            e_sack[md_owner]          = forced || m_ack;
            e_srd[md_owner*32 +: 32]  = forced ? TD : m_rdata;
        end
        e_grant = md_owned ? (N'(1) << md_owner) : '0;
        check("rnd_mbus",  128'({m_cyc, m_stb, m_we, m_adr, m_wdata}), 128'(e_mbus));
        check("rnd_sack",  128'(s_ack), 128'(e_sack));
        check("rnd_srd",   128'(s_rdata), 128'(e_srd));
        check("rnd_grant", 128'(grant), 128'(e_grant));
        check("rnd_tcnt",  128'(timeout_count), 128'(md_tcount));
    endtask

    task automatic model_update();
        bit forced;
        forced = md_owned && (md_stall == T);
        if (!rst_n) begin
            model_reset();
        end else if (!md_owned) begin
            md_stall = 0;
            for (int k = 1; k <= N; k++) begin
                if (!md_owned && s_cyc[(md_last + k) % N]) begin
                    md_owned = 1;
                    md_owner = (md_last + k) % N;
                end
            end
        end else begin
            if (forced && md_tcount < 65535) md_tcount++;
            if (!s_cyc[md_owner]) begin
                md_owned = 0;
                md_last  = md_owner;
                md_stall = 0;
            end else if (forced) begin
                md_stall = 0;
            end else if (s_stb[md_owner] && !m_ack) begin
                md_stall++;
            end else begin
                md_stall = 0;
            end
        end
    endtask

    task automatic rand_drive(input int ack_div, input int drop_div);
        rst_n = ($urandom_range(0, 499) != 0);
        for (int i = 0; i < N; i++) begin
            if (!s_cyc[i]) begin
                if ($urandom_range(0, 3) == 0) begin
                    s_cyc[i] = 1'b1;
                    s_stb[i] = 1'b1;
                    s_we[i]  = 1'($urandom_range(0, 1));
                    s_adr[i*32 +: 32]   = $urandom;
                    s_wdata[i*32 +: 32] = $urandom;
                end
            end else if ($urandom_range(0, drop_div - 1) == 0) begin
                s_cyc[i] = 1'b0;
                s_stb[i] = 1'b0;
            end else begin
                s_stb[i] = s_stb[i] ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) begin
                    s_adr[i*32 +: 32]   = $urandom;
                    s_wdata[i*32 +: 32] = $urandom;
                end
            end
        end
        m_ack   = ($urandom_range(0, ack_div - 1) == 0);
        m_rdata = $urandom;
    endtask

    initial begin
        int           first_ack;
        int           acks;
        logic         fm_cyc, fm_stb;
        logic [31:0]  f_dat;
        logic [31:0]  e_adr;
        logic         e_we;
        logic [N*32-1:0] e_rd;

        tbl[0]  = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000};
        tbl[1]  = '{1'b1, 3'b001, 1'b0, 3'b000, 1'b0, 3'b000};
        tbl[2]  = '{1'b1, 3'b001, 1'b0, 3'b001, 1'b1, 3'b000};
        tbl[3]  = '{1'b1, 3'b001, 1'b1, 3'b001, 1'b1, 3'b001};
        tbl[4]  = '{1'b1, 3'b000, 1'b0, 3'b001, 1'b0, 3'b000};
        tbl[5]  = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000};
        tbl[6]  = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000};
        tbl[7]  = '{1'b1, 3'b011, 1'b0, 3'b000, 1'b0, 3'b000};
        tbl[8]  = '{1'b1, 3'b011, 1'b1, 3'b001, 1'b1, 3'b001};
        tbl[9]  = '{1'b1, 3'b010, 1'b0, 3'b001, 1'b0, 3'b000};
        tbl[10] = '{1'b1, 3'b010, 1'b0, 3'b000, 1'b0, 3'b000};
        tbl[11] = '{1'b1, 3'b011, 1'b1, 3'b010, 1'b1, 3'b010};
        tbl[12] = '{1'b1, 3'b001, 1'b0, 3'b010, 1'b0, 3'b000};
        tbl[13] = '{1'b1, 3'b001, 1'b0, 3'b000, 1'b0, 3'b000};
        tbl[14] = '{1'b1, 3'b011, 1'b1, 3'b001, 1'b1, 3'b001};
        tbl[15] = '{1'b1, 3'b010, 1'b0, 3'b001, 1'b0, 3'b000};
        tbl[16] = '{1'b1, 3'b010, 1'b0, 3'b000, 1'b0, 3'b000};
        tbl[17] = '{1'b1, 3'b010, 1'b1, 3'b010, 1'b1, 3'b010};
        tbl[18] = '{1'b1, 3'b000, 1'b0, 3'b010, 1'b0, 3'b000};
        tbl[19] = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000};
        tbl[20] = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 3'b000};
        tbl[21] = '{1'b1, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000};
        tbl[22] = '{1'b1, 3'b111, 1'b1, 3'b100, 1'b1, 3'b100};
        tbl[23] = '{1'b1, 3'b011, 1'b0, 3'b100, 1'b0, 3'b000};
        tbl[24] = '{1'b1, 3'b011, 1'b0, 3'b000, 1'b0, 3'b000};
        tbl[25] = '{1'b1, 3'b011, 1'b1, 3'b001, 1'b1, 3'b001};
        tbl[26] = '{1'b1, 3'b010, 1'b0, 3'b001, 1'b0, 3'b000};
        tbl[27] = '{1'b1, 3'b010, 1'b0, 3'b000, 1'b0, 3'b000};
        tbl[28] = '{1'b1, 3'b010, 1'b1, 3'b010, 1'b1, 3'b010};
        tbl[29] = '{1'b1, 3'b000, 1'b0, 3'b010, 1'b0, 3'b000};
        tbl[30] = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000};

        rst_n = 1'b0;
        clear_inputs();
        tick();

        // Directed table: master j reads/writes address j*0x100, slave data is 1.
        for (int r = 0; r < 31; r++) begin
            rst_n   = tbl[r].rst_n;
            s_cyc   = tbl[r].cyc;
            s_stb   = tbl[r].cyc;
            s_we    = 3'b010;
            for (int j = 0; j < N; j++) begin
                s_adr[j*32 +: 32]   = 32'(j) * 32'h100;
                s_wdata[j*32 +: 32] = 32'hA000_0000 + 32'(j);
            end
            m_ack   = tbl[r].ack;
            m_rdata = 32'h1;
            @(negedge clk);
            e_adr = '0;
            e_we  = 1'b0;
            e_rd  = '0;
            for (int j = 0; j < N; j++) begin
                if (tbl[r].rst_n && tbl[r].eg[j]) begin
                    e_adr = 32'(j) * 32'h100;
                    e_we  = (j == 1);
                    e_rd[j*32 +: 32] = 32'h1;
                end
            end
            check($sformatf("tbl%0d_grant", r), 128'(grant), 128'(tbl[r].eg));
            check($sformatf("tbl%0d_mcyc", r),  128'(m_cyc), 128'(tbl[r].emcyc));
            check($sformatf("tbl%0d_mstb", r),  128'(m_stb), 128'(tbl[r].emcyc));
            check($sformatf("tbl%0d_sack", r),  128'(s_ack), 128'(tbl[r].esack));
            check($sformatf("tbl%0d_madr", r),  128'(m_adr), 128'(e_adr));
            check($sformatf("tbl%0d_mwe", r),   128'(m_we),  128'(e_we));
            check($sformatf("tbl%0d_srd", r),   128'(s_rdata), 128'(e_rd));
            tick();
        end

        // Locked burst: master 1 owns for 4 beats while master 0 waits.
        do_reset();
        set_master(1, 1'b1, 1'b1);
        @(negedge clk);
        check("burst_idle_grant", 128'(grant), 128'(3'b000));
        tick();
        set_master(0, 1'b1, 1'b1);
        acks = 0;
        for (int b = 0; b < 4; b++) begin
            m_ack = 1'b0;
            @(negedge clk);
            check($sformatf("burst%0d_wait_grant", b), 128'(grant), 128'(3'b010));
            check($sformatf("burst%0d_wait_sack", b),  128'(s_ack), 128'(3'b000));
            tick();
            m_ack   = 1'b1;
            m_rdata = 32'h10 + 32'(b);
            @(negedge clk);
            if (s_ack[1]) acks++;
            check($sformatf("burst%0d_grant", b), 128'(grant), 128'(3'b010));
            check($sformatf("burst%0d_sack", b),  128'(s_ack), 128'(3'b010));
            check($sformatf("burst%0d_data", b),  128'(s_rdata[32 +: 32]), 128'(32'h10 + 32'(b)));
            tick();
        end
        check("burst_ack_total", 128'(acks), 128'(4));
        m_ack = 1'b0;
        set_master(1, 1'b0, 1'b0);
        @(negedge clk);
        check("burst_release_mcyc", 128'(m_cyc), 128'(1'b0));
        tick();
        @(negedge clk);
        check("burst_gap_grant", 128'(grant), 128'(3'b000));
        tick();
        @(negedge clk);
        check("burst_next_grant", 128'(grant), 128'(3'b001));
        check("burst_next_mcyc",  128'(m_cyc), 128'(1'b1));
        tick();

        // Timeout: slave never acks; forced ack expected on the 17th owned cycle.
        do_reset();
        set_master(0, 1'b1, 1'b1);
        tick();
        first_ack = 0;
        fm_cyc = 1'b1;
        fm_stb = 1'b1;
        f_dat  = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (s_ack[0]) begin
                first_ack = k;
                fm_cyc = m_cyc;
                fm_stb = m_stb;
                f_dat  = s_rdata[31:0];
                break;
            end
            tick();
        end
        check("to_ack_cycle", 128'(first_ack), 128'(17));
        check("to_data",      128'(f_dat),     128'(TD));
        check("to_mcyc",      128'(fm_cyc),    128'(1'b0));
        check("to_mstb",      128'(fm_stb),    128'(1'b0));
        tick();
        m_ack   = 1'b1;
        m_rdata = 32'h55;
        @(negedge clk);
        check("to_count",       128'(timeout_count), 128'(16'd1));
        check("to_after_grant", 128'(grant), 128'(3'b001));
        check("to_after_mcyc",  128'(m_cyc), 128'(1'b1));
        check("to_after_data",  128'(s_rdata[31:0]), 128'(32'h55));
        tick();

        // Race: slave acks on the threshold cycle; no forced termination.
        m_ack = 1'b0;
        set_master(0, 1'b0, 1'b0);
        tick();
        tick();
        set_master(0, 1'b1, 1'b1);
        tick();
        acks = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (s_ack[0]) acks++;
            tick();
        end
        check("race_no_early_ack", 128'(acks), 128'(0));
        m_ack   = 1'b1;
        m_rdata = 32'h1234;
        @(negedge clk);
        check("race_sack", 128'(s_ack), 128'(3'b001));
        check("race_data", 128'(s_rdata[31:0]), 128'(32'h1234));
        check("race_mcyc", 128'(m_cyc), 128'(1'b1));
        tick();
        m_ack = 1'b0;
        @(negedge clk);
        check("race_no_forced", 128'(s_ack), 128'(3'b000));
        check("race_count",     128'(timeout_count), 128'(16'd1));
        tick();

        // Reset mid-transfer while master 1 owns the bus.
        do_reset();
        set_master(1, 1'b1, 1'b1);
        tick();
        @(negedge clk);
        check("rst_owned_grant", 128'(grant), 128'(3'b010));
        tick();
        rst_n = 1'b0;
        m_ack = 1'b1;
        set_master(0, 1'b1, 1'b1);
        @(negedge clk);
        check("rst_mcyc", 128'(m_cyc), 128'(1'b0));
        check("rst_mstb", 128'(m_stb), 128'(1'b0));
        check("rst_sack", 128'(s_ack), 128'(3'b000));
        tick();
        rst_n = 1'b1;
        m_ack = 1'b0;
        @(negedge clk);
        check("rst_grant_cleared", 128'(grant), 128'(3'b000));
        tick();
        @(negedge clk);
        check("rst_next_grant", 128'(grant), 128'(3'b001));
        tick();

        // Randomized traffic against the model: busy slave, then slow slave.
        do_reset();
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c < 1500) rand_drive(3, 16);
            else          rand_drive(40, 64);
            @(negedge clk);
            model_check();
            model_update();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
